// File: rtl/key_capture_pkg.sv
// rtl/key_capture_pkg.sv - register offsets shared by the key capture block
package key_capture_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

endpackage

// File: rtl/nios_system_key_capture_if.sv
// rtl/nios_system_key_capture_if.sv - Avalon-MM slave bus plus interrupt line
interface nios_system_key_capture_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );

endinterface

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - one button: normalise, synchronise, debounce, flag rises
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic key_in,
    output logic stable,
    output logic rise
);

    localparam int             CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          pressed;
    logic          meta_q, meta_d;
    logic          sync_q, sync_d;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign pressed = ACTIVE_LOW ? ~key_in : key_in;

    // Count consecutive cycles the synchronised level disagrees with the
    // accepted level; accept it once it has held for DEBOUNCE_CYCLES.
    always_comb begin
        meta_d   = pressed;
        sync_d   = meta_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            stable_d = sync_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Synchroniser, counter and accepted-level state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            meta_q   <= meta_d;
            sync_q   <= sync_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // Rise is taken from the next-state so the parent's edge flop updates on
    // the same clock edge as stable.
    assign stable = stable_q;
    assign rise   = stable_d & ~stable_q;

endmodule

// File: rtl/nios_system_key_capture.sv
// rtl/nios_system_key_capture.sv - debounced pushbutton PIO with edge capture and irq
module nios_system_key_capture
    import key_capture_pkg::*;
#(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    nios_system_key_capture_if.slave  bus,
    input  logic [WIDTH-1:0]          key_in
);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic             wr_en;
    logic [31:0]      rd;
    logic             unused_writedata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_debounce (
            .clk    (clk),
            .reset  (reset),
            .key_in (key_in[i]),
            .stable (stable[i]),
            .rise   (rise[i])
        );
    end

    // Register writes; a press on the same edge as a clear keeps the bit set.
    always_comb begin
        wr_en      = bus.chipselect & ~bus.write_n;
        irqmask_d  = irqmask_q;
        edge_cap_d = edge_cap_q | rise;
        if (wr_en && bus.address == ADDR_IRQMASK) begin
            irqmask_d = bus.writedata[WIDTH-1:0];
        end
        if (wr_en && bus.address == ADDR_EDGECAP) begin
            edge_cap_d = (edge_cap_q & ~bus.writedata[WIDTH-1:0]) | rise;
        end
    end

    // Mask and edgecapture registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irqmask_q  <= '0;
            edge_cap_q <= '0;
        end else begin
            irqmask_q  <= irqmask_d;
            edge_cap_q <= edge_cap_d;
        end
    end

    // Zero-wait read mux, decoded regardless of chipselect.
    always_comb begin
        rd = '0;
        case (bus.address)
            ADDR_DATA:    rd[WIDTH-1:0] = stable;
            ADDR_IRQMASK: rd[WIDTH-1:0] = irqmask_q;
            ADDR_EDGECAP: rd[WIDTH-1:0] = edge_cap_q;
            default:      rd = '0;
        endcase
    end

    assign bus.readdata     = rd;
    assign bus.irq          = |(edge_cap_q & irqmask_q);
    assign unused_writedata = &{1'b0, bus.writedata};

endmodule

// File: tb/tb_nios_system_key_capture.sv
// tb/tb_nios_system_key_capture.sv - directed and randomized checks of the key capture PIO
module tb_nios_system_key_capture;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] key_in = 2'b11;
    int         tests = 0;
    int         failed = 0;

    nios_system_key_capture_if bus();

    nios_system_key_capture #(
        .WIDTH           (2),
        .DEBOUNCE_CYCLES (4),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .key_in (key_in)
    );

    always #10 clk = ~clk;

    // Reference model: a sample is the pressed level seen at a clock edge.
    // The accepted level flips at edge n when the samples taken at edges
    // n-5..n-2 all agree and differ from it (two sync stages + 4 hold cycles).
    logic [1:0] hist[$];
    logic [1:0] m_stable, m_edge, m_mask;

    task automatic m_reset();
        hist.delete();
        repeat (5) hist.push_back(2'b00);
        m_stable = 2'b00;
        m_edge   = 2'b00;
        m_mask   = 2'b00;
    endtask

    task automatic m_clock();
        logic [1:0] nstab;
        logic [1:0] clr;
        nstab = m_stable;
        for (int i = 0; i < 2; i++) begin
            if (hist[0][i] == hist[1][i] && hist[1][i] == hist[2][i] &&
                hist[2][i] == hist[3][i] && hist[3][i] != m_stable[i])
                nstab[i] = hist[3][i];
        end
        clr = 2'b00;
        if (bus.chipselect && !bus.write_n && bus.address == 2'd3) clr = bus.writedata[1:0];
        if (bus.chipselect && !bus.write_n && bus.address == 2'd2) m_mask = bus.writedata[1:0];
        m_edge   = (m_edge & ~clr) | (nstab & ~m_stable);
        m_stable = nstab;
        hist.push_back(~key_in);
        void'(hist.pop_front());
    endtask

    function automatic logic [31:0] exp_rd(logic [1:0] a);
        case (a)
            2'd0:    return {30'd0, m_stable};
            2'd2:    return {30'd0, m_mask};
            2'd3:    return {30'd0, m_edge};
            default: return 32'd0;
        endcase
    endfunction

    task automatic cyc();
        @(posedge clk);
        if (reset) m_reset();
        else m_clock();
        @(negedge clk);
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd_chk(string tag, logic [1:0] a, logic [31:0] exp);
        bus.address = a;
        #1;
        chk(tag, bus.readdata, exp);
    endtask

    task automatic wr(logic [1:0] a, logic [31:0] d);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = a;
        bus.writedata  = d;
        cyc();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    initial begin
        int         hold;
        int         r;
        logic [1:0] ra;

        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'd0;
        m_reset();

        // Reset state, then a button press and mask to make state nonzero.
        cyc();
        cyc();
        rd_chk("rst_data", 2'd0, 32'd0);
        rd_chk("rst_edge", 2'd3, 32'd0);
        reset = 1'b0;
        wr(2'd2, 32'h3);
        key_in = 2'b10;
        repeat (8) cyc();
        rd_chk("pre_rst_edge", 2'd3, 32'h1);

        // Asynchronous reset mid-cycle clears everything immediately.
        #2;
        reset = 1'b1;
        m_reset();
        rd_chk("arst_data", 2'd0, 32'd0);
        rd_chk("arst_mask", 2'd2, 32'd0);
        rd_chk("arst_edge", 2'd3, 32'd0);
        chk("arst_irq", {31'd0, bus.irq}, 32'd0);
        cyc();
        key_in = 2'b11;
        cyc();
        reset = 1'b0;
        repeat (8) cyc();
        rd_chk("rel_data", 2'd0, 32'd0);
        rd_chk("rel_edge", 2'd3, 32'd0);

        // Clean press: nothing visible through edge k+4, both set at k+5.
        key_in = 2'b10;
        for (int j = 0; j < 5; j++) begin
            cyc();
            rd_chk("press_early_data", 2'd0, 32'd0);
            rd_chk("press_early_edge", 2'd3, 32'd0);
        end
        cyc();
        rd_chk("press_data", 2'd0, 32'h1);
        rd_chk("press_edge", 2'd3, 32'h1);
        key_in = 2'b11;
        repeat (8) cyc();
        rd_chk("release_data", 2'd0, 32'd0);
        rd_chk("release_edge", 2'd3, 32'h1);
        wr(2'd3, 32'h3);
        rd_chk("clear_edge", 2'd3, 32'd0);

        // Glitch of three samples is rejected.
        key_in = 2'b10;
        repeat (3) cyc();
        key_in = 2'b11;
        for (int j = 0; j < 8; j++) begin
            cyc();
            rd_chk("glitch_data", 2'd0, 32'd0);
            rd_chk("glitch_edge", 2'd3, 32'd0);
        end

        // Interrupt and write-1-to-clear.
        wr(2'd2, 32'h1);
        rd_chk("mask_rd", 2'd2, 32'h1);
        chk("irq_idle", {31'd0, bus.irq}, 32'd0);
        key_in = 2'b10;
        repeat (6) cyc();
        chk("irq_set", {31'd0, bus.irq}, 32'd1);
        wr(2'd3, 32'h1);
        rd_chk("irq_clr_edge", 2'd3, 32'd0);
        chk("irq_clr", {31'd0, bus.irq}, 32'd0);
        repeat (6) cyc();
        key_in = 2'b11;
        repeat (8) cyc();
        rd_chk("no_release_edge", 2'd3, 32'd0);
        chk("no_release_irq", {31'd0, bus.irq}, 32'd0);
        rd_chk("irq_rel_data", 2'd0, 32'd0);

        // Set wins over a same-edge clear of bit 1.
        key_in = 2'b01;
        repeat (5) cyc();
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = 2'd3;
        bus.writedata  = 32'h2;
        cyc();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        rd_chk("collide_edge", 2'd3, 32'h2);
        rd_chk("collide_data", 2'd0, 32'h2);
        key_in = 2'b11;
        repeat (8) cyc();
        wr(2'd3, 32'h3);

        // Reset at count 2 while held: a fresh press qualifies from scratch.
        key_in = 2'b10;
        repeat (4) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        for (int j = 0; j < 5; j++) begin
            cyc();
            rd_chk("rst_mid_early", 2'd3, 32'd0);
        end
        cyc();
        rd_chk("rst_mid_edge", 2'd3, 32'h1);
        rd_chk("rst_mid_data", 2'd0, 32'h1);
        key_in = 2'b11;
        repeat (8) cyc();
        wr(2'd3, 32'h3);

        // Randomized keys and register traffic against the model.
        hold = 0;
        for (int c = 0; c < 400; c++) begin
            if (hold == 0) begin
                key_in = 2'($urandom);
                hold   = $urandom_range(1, 7);
            end
            hold--;
            r = $urandom_range(0, 9);
            if (r < 2) begin
                bus.chipselect = 1'b1;
                bus.write_n    = 1'b0;
                bus.address    = 2'($urandom);
                bus.writedata  = $urandom;
            end else if (r == 2) begin
                bus.chipselect = 1'b0;
                bus.write_n    = 1'b0;
                bus.address    = 2'($urandom);
                bus.writedata  = $urandom;
            end else begin
                bus.chipselect = 1'($urandom);
                bus.write_n    = 1'b1;
            end
            cyc();
            bus.chipselect = 1'b0;
            bus.write_n    = 1'b1;
            ra = 2'($urandom);
            rd_chk("rand_rd", ra, exp_rd(ra));
            chk("rand_irq", {31'd0, bus.irq}, {31'd0, |(m_edge & m_mask)});
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/nios_system_key_capture.md
# nios_system_key_capture

Avalon-MM input slave that samples the board pushbuttons, synchronises and debounces each line, and latches press events for the Nios II. It is the input-side neighbour of the system's output PIO registers. The Nios II polls or takes an interrupt from this block to read button activity, then drives the output PIOs in response. Zero-wait-state reads and writes; the register map follows the Altera PIO offsets.

## Interface
Parameters:
- WIDTH, 2: number of button lines.
- DEBOUNCE_CYCLES, 500000: cycles a changed level must hold before it is accepted (10 ms at 50 MHz). Legal range is 2 or more.
- ACTIVE_LOW, 1: when set, key_in low means pressed.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  2  register word offset.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, combinational.
- irq  out  1  interrupt request, active-high.
- key_in  in  WIDTH  raw asynchronous button pins.

## Operation
- Normalisation: p = ACTIVE_LOW ? ~key_in : key_in. After normalisation, 1 means pressed everywhere in the block.
- Each bit has a 2-flop synchroniser producing sync[i].
- Each bit has a debounce counter cnt[i] of width $clog2(DEBOUNCE_CYCLES). Per clock:
  - If sync[i] == stable[i], cnt[i] is set to 0.
  - Otherwise, if cnt[i] == DEBOUNCE_CYCLES-1, stable[i] is set to sync[i] and cnt[i] to 0.
  - Otherwise cnt[i] increments by 1.
- A glitch shorter than DEBOUNCE_CYCLES never changes stable.
- Press event: on the edge where stable[i] goes 0->1, edge[i] is set to 1. Releases (1->0) set nothing.
- Register map (word offsets):
  - 0 data: RO, returns stable.
  - 1: reads 0, writes are ignored.
  - 2 irqmask: RW, low WIDTH bits.
  - 3 edgecapture: read returns edge; a write clears every bit where writedata is 1.
- readdata is zero-extended above WIDTH. When chipselect is low, readdata still reflects the addressed register (Avalon ignores it).
- A write occurs when chipselect && !write_n. Writes to offset 0 are ignored.
- Simultaneous events: if a press event and a write-1-to-clear hit the same edge bit in the same cycle, the set wins and the bit stays 1.
- irq = |(edge & irqmask). It is combinational from registers, so it has no glitch from key_in.

## Timing
- Reset values (asserted asynchronously, held while reset is high):
  - sync flops, stable, cnt, edge and irqmask are all 0, i.e. released.
  - Outputs: readdata is 0 for every address, irq is 0.
- Press latency: key_in changes before clock edge k. sync[i] updates at edge k+1. stable[i] and edge[i] update at edge k+1+DEBOUNCE_CYCLES. irq rises in the same cycle if masked in.
- Register write latency: mask and edgecapture writes take effect at the next edge. A read in the following cycle sees the new value, and irq follows in that same cycle.
- Reset mid-debounce: partial counts are discarded. After reset is released, a button that is still held re-qualifies from cnt = 0 and produces a fresh press event.
- Counter arithmetic: cnt never exceeds DEBOUNCE_CYCLES-1, so it cannot wrap.

## Structure
- Package key_capture_pkg holds the offset constants ADDR_DATA=0, ADDR_IRQMASK=2, ADDR_EDGECAP=3.
- Sub-module key_debounce handles one bit: normalisation input, synchroniser, counter and stable flop. It outputs stable and a one-cycle rise pulse.
- The top level generates WIDTH instances of key_debounce and adds the Avalon register file, the edgecapture logic and irq.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, ACTIVE_LOW=1.
- Reset: assert reset mid-cycle -> readdata=0 at offsets 0/2/3 and irq=0 immediately; release with key_in=2'b11 -> data stays 0.
- Clean press: drive key_in=2'b10 before edge k -> data reads 2'b01 and edgecapture reads 2'b01 from edge k+5. Neither reads nonzero before k+5.
- Glitch rejection: key_in[0] low for 3 cycles, then high -> data and edgecapture remain 0 indefinitely.
- Interrupt and clear: write irqmask=2'b01, then press button 0 -> irq=1. Write offset 3 with 0x1 -> edgecapture=0 and irq=0 the next cycle. A release produces no new edge.
- Set-vs-clear collision: time a write-1-to-clear of bit 1 on the same edge that stable[1] rises -> edgecapture[1]=1 afterwards.
- Reset mid-debounce: press, pulse reset at count 2 while still held, then release reset -> press event occurs 5 edges after release, and edgecapture=2'b01.
